// File: rtl/lcd_hex_driver.sv
// HD44780 16x2 character-LCD driver: power-up wait, init commands, then a continuous
// two-line refresh of 17 hex nibbles snapshotted once per frame (8-bit bus mode).
module lcd_hex_driver #(
    parameter int EN_PULSE = 16,
    parameter int CMD_WAIT = 2500,
    parameter int CLR_WAIT = 100000,
    parameter int PWR_WAIT = 1000000
) (
    input  logic       LCDH_clk,
    input  logic       LCDH_rst_n,
    input  logic [3:0] LCDH_x1,
    input  logic [3:0] LCDH_x2,
    input  logic [3:0] LCDH_x3,
    input  logic [3:0] LCDH_x4,
    input  logic [3:0] LCDH_x5,
    input  logic [3:0] LCDH_x6,
    input  logic [3:0] LCDH_x7,
    input  logic [3:0] LCDH_x8,
    input  logic [3:0] LCDH_z1,
    input  logic [3:0] LCDH_z2,
    input  logic [3:0] LCDH_z3,
    input  logic [3:0] LCDH_z4,
    input  logic [3:0] LCDH_z5,
    input  logic [3:0] LCDH_z6,
    input  logic [3:0] LCDH_z7,
    input  logic [3:0] LCDH_z8,
    input  logic [3:0] LCDH_y,
    output logic [7:0] LCDH_data,
    output logic       LCDH_rs,
    output logic       LCDH_rw,
    output logic       LCDH_en,
    output logic       LCDH_on,
    output logic       LCDH_frame_done
);

    typedef enum logic [2:0] {PWRUP, INIT, SNAP, LINE1, LINE2} top_state_e;
    typedef enum logic [1:0] {SETUP, PULSE, WAIT} byte_phase_e;

    // Down-counter reload values: a load of N-1 followed by the zero cycle gives N cycles.
    // PWRUP spends its first cycle loading, hence the -2.
    localparam logic [23:0] PULSE_LOAD = 24'(EN_PULSE - 1);
    localparam logic [23:0] CMD_LOAD   = 24'(CMD_WAIT - 1);
    localparam logic [23:0] CLR_LOAD   = 24'(CLR_WAIT - 1);
    localparam logic [23:0] PWR_LOAD   = 24'(PWR_WAIT - 2);

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_Y     = 8'h59;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CMD_CLR  = 8'h01;
    localparam logic [7:0] CMD_L1   = 8'h80;
    localparam logic [7:0] CMD_L2   = 8'hC0;

    top_state_e       state;
    byte_phase_e      phase;
    logic [23:0]      wait_cnt;
    logic [3:0]       col;
    logic             char_phase;   // 0 while the line-address command is in flight
    logic [3:0]       snap_y;
    logic [7:0][3:0]  snap_x;       // [0] is the leftmost digit
    logic [7:0][3:0]  snap_z;

    // Next-byte selection, consumed only when the current byte's wait expires
    top_state_e       nxt_state;
    logic [3:0]       nxt_col;
    logic             nxt_char_phase;
    logic [7:0]       nxt_data;
    logic             nxt_rs;
    logic             nxt_frame_done;
    logic [3:0]       char_col;
    logic [2:0]       digit_idx;
    logic [7:0]       line1_char;
    logic [7:0]       line2_char;
    logic             is_clear;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: return 8'h38;   // 8-bit bus, two lines, 5x8 font
            3'd2:       return 8'h0C;   // display on, cursor off
            3'd3:       return CMD_CLR;
            default:    return 8'h06;   // entry mode: increment, no shift
        endcase
    endfunction

    assign LCDH_rw  = 1'b0;
    assign is_clear = !LCDH_rs && (LCDH_data == CMD_CLR);

    always_comb begin
        char_col  = char_phase ? col + 4'd1 : 4'd0;
        digit_idx = 3'(char_col - 4'd4);

        case (char_col)
            4'd0:                           line1_char = CH_Y;
            4'd1:                           line1_char = hex_ascii(snap_y);
            4'd2:                           line1_char = CH_COLON;
            4'd3, 4'd12, 4'd13, 4'd14, 4'd15: line1_char = CH_SPACE;
            default:                        line1_char = hex_ascii(snap_x[digit_idx]);
        endcase

        if (char_col >= 4'd4 && char_col <= 4'd11)
            line2_char = hex_ascii(snap_z[digit_idx]);
        else
            line2_char = CH_SPACE;
    end

    // NOTE: every output of a combinational block gets a default before the case,
    // otherwise the unassigned paths hold their value and infer latches.
    always_comb begin
        nxt_state      = state;
        nxt_col        = col;
        nxt_char_phase = char_phase;
        nxt_data       = LCDH_data;
        nxt_rs         = LCDH_rs;
        nxt_frame_done = 1'b0;

        case (state)
            INIT: begin
                if (col == 4'd4) begin
                    nxt_state = SNAP;
                    nxt_col   = 4'd0;
                end else begin
                    nxt_col  = col + 4'd1;
                    nxt_data = init_cmd(3'(col + 4'd1));
                    nxt_rs   = 1'b0;
                end
            end
            LINE1: begin
                if (char_phase && col == 4'd15) begin
                    nxt_state      = LINE2;
                    nxt_col        = 4'd0;
                    nxt_char_phase = 1'b0;
                    nxt_data       = CMD_L2;
                    nxt_rs         = 1'b0;
                end else begin
                    nxt_col        = char_col;
                    nxt_char_phase = 1'b1;
                    nxt_data       = line1_char;
                    nxt_rs         = 1'b1;
                end
            end
            LINE2: begin
                if (char_phase && col == 4'd15) begin
                    nxt_state      = SNAP;
                    nxt_col        = 4'd0;
                    nxt_char_phase = 1'b0;
                    nxt_frame_done = 1'b1;
                end else begin
                    nxt_col        = char_col;
                    nxt_char_phase = 1'b1;
                    nxt_data       = line2_char;
                    nxt_rs         = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the snapshot registers are reset along with the control state, so a
    // frame can never show power-on garbage even if SNAP timing is later changed.
    always_ff @(posedge LCDH_clk or negedge LCDH_rst_n) begin
        if (!LCDH_rst_n) begin
            state           <= PWRUP;
            phase           <= SETUP;
            wait_cnt        <= '0;
            col             <= '0;
            char_phase      <= 1'b0;
            snap_y          <= '0;
            snap_x          <= '0;
            snap_z          <= '0;
            LCDH_data       <= '0;
            LCDH_rs         <= 1'b0;
            LCDH_en         <= 1'b0;
            LCDH_on         <= 1'b0;
            LCDH_frame_done <= 1'b0;
        end else begin
            LCDH_frame_done <= 1'b0;
            case (state)
                PWRUP: begin
                    // LCDH_on is still low only on the first cycle after reset
                    if (!LCDH_on) begin
                        LCDH_on  <= 1'b1;
                        wait_cnt <= PWR_LOAD;
                    end else if (wait_cnt == '0) begin
                        state     <= INIT;
                        phase     <= SETUP;
                        col       <= '0;
                        LCDH_data <= init_cmd(3'd0);
                        LCDH_rs   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 24'd1;
                    end
                end
                SNAP: begin
                    snap_y     <= LCDH_y;
                    snap_x     <= {LCDH_x8, LCDH_x7, LCDH_x6, LCDH_x5,
                                   LCDH_x4, LCDH_x3, LCDH_x2, LCDH_x1};
                    snap_z     <= {LCDH_z8, LCDH_z7, LCDH_z6, LCDH_z5,
                                   LCDH_z4, LCDH_z3, LCDH_z2, LCDH_z1};
                    state      <= LINE1;
                    phase      <= SETUP;
                    col        <= '0;
                    char_phase <= 1'b0;
                    LCDH_data  <= CMD_L1;
                    LCDH_rs    <= 1'b0;
                end
                default: begin
                    case (phase)
                        SETUP: begin
                            LCDH_en  <= 1'b1;
                            phase    <= PULSE;
                            wait_cnt <= PULSE_LOAD;
                        end
                        PULSE: begin
                            if (wait_cnt == '0) begin
                                LCDH_en  <= 1'b0;
                                phase    <= WAIT;
                                wait_cnt <= is_clear ? CLR_LOAD : CMD_LOAD;
                            end else begin
                                wait_cnt <= wait_cnt - 24'd1;
                            end
                        end
                        default: begin
                            if (wait_cnt == '0) begin
                                state           <= nxt_state;
                                phase           <= SETUP;
                                col             <= nxt_col;
                                char_phase      <= nxt_char_phase;
                                LCDH_data       <= nxt_data;
                                LCDH_rs         <= nxt_rs;
                                LCDH_frame_done <= nxt_frame_done;
                            end else begin
                                wait_cnt <= wait_cnt - 24'd1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Scoreboard bench for lcd_hex_driver: expected LCD bytes are queued from a string-level
// model of the display; a negedge monitor pops and compares on every en rise.
module tb_lcd_hex_driver;

    localparam int EN_PULSE = 2;
    localparam int CMD_WAIT = 4;
    localparam int CLR_WAIT = 8;
    localparam int PWR_WAIT = 10;
    localparam int BYTE_CYC = 1 + EN_PULSE + CMD_WAIT;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        logic [7:0] gap;   // en fall-to-rise cycles before this byte, 0 = not checked
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] y;
    logic [7:0][3:0] xs, zs;
    logic [7:0] data;
    logic rs, rw, en, on, frame_done;

    int n_checks = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    int cyc = 0, rise_cnt = 0, fd_count = 0;
    int rise_cyc = 0, fall_cyc = 0, r80_cyc = -1, bytes_since_80 = -1;
    logic prev_en = 1'b0, prev_fd = 1'b0, have_fall = 1'b0, fd_seen = 1'b0;
    logic [8:0] cur_byte = '0;

    always #5 clk = ~clk;

    lcd_hex_driver #(
        .EN_PULSE(EN_PULSE), .CMD_WAIT(CMD_WAIT), .CLR_WAIT(CLR_WAIT), .PWR_WAIT(PWR_WAIT)
    ) dut (
        .LCDH_clk(clk), .LCDH_rst_n(rst_n),
        .LCDH_x1(xs[0]), .LCDH_x2(xs[1]), .LCDH_x3(xs[2]), .LCDH_x4(xs[3]),
        .LCDH_x5(xs[4]), .LCDH_x6(xs[5]), .LCDH_x7(xs[6]), .LCDH_x8(xs[7]),
        .LCDH_z1(zs[0]), .LCDH_z2(zs[1]), .LCDH_z3(zs[2]), .LCDH_z4(zs[3]),
        .LCDH_z5(zs[4]), .LCDH_z6(zs[5]), .LCDH_z7(zs[6]), .LCDH_z8(zs[7]),
        .LCDH_y(y),
        .LCDH_data(data), .LCDH_rs(rs), .LCDH_rw(rw), .LCDH_en(en),
        .LCDH_on(on), .LCDH_frame_done(frame_done)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        int v = int'(n);
        return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
    endfunction

    task automatic push_init();
        exp_q.push_back('{1'b0, 8'h38, 8'd0});
        exp_q.push_back('{1'b0, 8'h38, 8'(CMD_WAIT + 1)});
        exp_q.push_back('{1'b0, 8'h0C, 8'(CMD_WAIT + 1)});
        exp_q.push_back('{1'b0, 8'h01, 8'(CMD_WAIT + 1)});
        exp_q.push_back('{1'b0, 8'h06, 8'(CLR_WAIT + 1)});
    endtask

    // Frame as it should read on the glass; the 0x80 byte follows the SNAP cycle.
    task automatic push_frame(input logic [3:0] fy, input logic [7:0][3:0] fx,
                              input logic [7:0][3:0] fz);
        logic [7:0] l1 [16];
        logic [7:0] l2 [16];
        for (int c = 0; c < 16; c++) begin
            l1[c] = 8'h20;
            l2[c] = 8'h20;
        end
        l1[0] = 8'h59;
        l1[1] = to_ascii(fy);
        l1[2] = 8'h3A;
        for (int i = 0; i < 8; i++) begin
            l1[4 + i] = to_ascii(fx[i]);
            l2[4 + i] = to_ascii(fz[i]);
        end
        exp_q.push_back('{1'b0, 8'h80, 8'(CMD_WAIT + 2)});
        for (int c = 0; c < 16; c++) exp_q.push_back('{1'b1, l1[c], 8'(CMD_WAIT + 1)});
        exp_q.push_back('{1'b0, 8'hC0, 8'(CMD_WAIT + 1)});
        for (int c = 0; c < 16; c++) exp_q.push_back('{1'b1, l2[c], 8'(CMD_WAIT + 1)});
    endtask

    task automatic wait_rises(input int target);
        for (int i = 0; i < 3000 && rise_cnt < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (rise_cnt < target) check("rise_timeout", rise_cnt, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, int'(en), 0);
        check({tag, "_data"}, int'(data), 0);
        check({tag, "_rs"}, int'(rs), 0);
        check({tag, "_rw"}, int'(rw), 0);
        check({tag, "_on"}, int'(on), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    // Release reset and measure cycles to the first en rise (PWR_WAIT + SETUP).
    task automatic release_and_check();
        int n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 200 && n == 0; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) check("on_after_release", int'(on), 1);
            if (en) n = i;
        end
        check("first_en_delay", n, PWR_WAIT + 1);
        check("first_cmd_data", int'(data), 8'h38);
        check("first_cmd_rs", int'(rs), 0);
    endtask

    task automatic randomize_inputs();
        y = 4'($urandom_range(0, 15));
        for (int i = 0; i < 8; i++) begin
            xs[i] = 4'($urandom_range(0, 15));
            zs[i] = 4'($urandom_range(0, 15));
        end
    endtask

    // Monitor: every en rise consumes one expected byte; widths, gaps, hold and frame_done
    // placement are checked against the byte-timing rules.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_en = 1'b0;
            prev_fd = 1'b0;
            have_fall = 1'b0;
            fd_seen = 1'b0;
            r80_cyc = -1;
            bytes_since_80 = -1;
        end else begin
            if (en && !prev_en) begin
                exp_t e;
                rise_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", int'({rs, data}), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_rs_data", int'({rs, data}), int'({e.rs, e.data}));
                    check("rw_low", int'(rw), 0);
                    if (e.gap != 0 && have_fall) check("byte_gap", cyc - fall_cyc, int'(e.gap));
                    if (!e.rs && e.data == 8'h80) begin
                        if (r80_cyc >= 0) check("frame_done_seen", int'(fd_seen), 1);
                        r80_cyc = cyc;
                        bytes_since_80 = 0;
                        fd_seen = 1'b0;
                    end
                end
                if (bytes_since_80 >= 0) bytes_since_80++;
                cur_byte = {rs, data};
                rise_cyc = cyc;
            end
            if (!en && prev_en) begin
                check("en_width", cyc - rise_cyc, EN_PULSE);
                check("byte_hold", int'({rs, data}), int'(cur_byte));
                fall_cyc = cyc;
                have_fall = 1'b1;
            end
            if (frame_done) begin
                fd_count++;
                // With the 0x80 SETUP cycle counted as cycle 1, the pulse lands in
                // cycle 34*BYTE_CYC+1, i.e. 34*BYTE_CYC-1 samples after the 0x80 en rise.
                check("frame_done_time", cyc - r80_cyc, 34 * BYTE_CYC - 1);
                check("frame_done_bytes", bytes_since_80, 34);
                if (prev_fd) check("frame_done_single", 1, 0);
                fd_seen = 1'b1;
            end
            prev_en = en;
            prev_fd = frame_done;
        end
    end

    initial begin
        int base;
        int fd_before;

        y = 4'hA;
        for (int i = 0; i < 8; i++) begin
            xs[i] = 4'(i + 1);
            zs[i] = 4'((i + 9) % 16);
        end

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");

        push_init();
        push_frame(y, xs, zs);
        base = rise_cnt;
        release_and_check();

        // Frame k: 0x80 is rise base+6+34k, line-1 char c is rise base+7+c+34k.
        for (int k = 0; k < 10; k++) begin
            wait_rises(base + 12 + 34 * k);
            case (k)
                0: xs[0] = 4'hF;
                1: xs = '0;
                2: for (int i = 0; i < 8; i++) xs[i] = 4'hF;
                3: for (int i = 0; i < 8; i++) xs[i] = 4'h9;
                4: for (int i = 0; i < 8; i++) xs[i] = 4'hA;
                default: randomize_inputs();
            endcase
            push_frame(y, xs, zs);
        end

        // Frame 10, line-2 char 3 (line-2 command is rise 23 of the frame).
        wait_rises(base + 34 * 10 + 27);
        check("en_high_before_reset", int'(en), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");

        exp_q.delete();
        randomize_inputs();
        repeat (3) @(negedge clk);
        push_init();
        push_frame(y, xs, zs);
        push_frame(y, xs, zs);
        fd_before = fd_count;
        base = rise_cnt;
        release_and_check();
        wait_rises(base + 5 + 34);
        repeat (12) @(negedge clk);
        check("frames_after_reset", fd_count - fd_before, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
